// File: rtl/dmap_wb_wa_line_cache.sv
// Direct-mapped, write-back, write-allocate cache with multi-word lines filled/evicted as word bursts.
// Define CACHE_FLUSH_EN to add flush_i/flush_done_o and a walk that writes back every dirty line.
module dmap_wb_wa_line_cache #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 32,
  parameter int unsigned LINE_WORDS = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [ADDR_WIDTH-1:0]   core_addr_i,
  input  logic [DATA_WIDTH-1:0]   core_wdata_i,
  input  logic                    core_write_i,
  input  logic [DATA_WIDTH/8-1:0] core_wstrb_i,
  input  logic                    core_read_i,
  output logic [DATA_WIDTH-1:0]   core_rdata_o,
  output logic                    core_ready_o,
  output logic [ADDR_WIDTH-1:0]   dmem_addr_o,
  output logic [DATA_WIDTH-1:0]   dmem_wdata_o,
  output logic                    dmem_write_o,
  output logic [DATA_WIDTH/8-1:0] dmem_wstrb_o,
  output logic                    dmem_read_o,
  input  logic [DATA_WIDTH-1:0]   dmem_rdata_i,
  input  logic                    dmem_ready_i
`ifdef CACHE_FLUSH_EN
  ,
  input  logic                    flush_i,
  output logic                    flush_done_o
`endif
);

  localparam int unsigned BYTES  = DATA_WIDTH / 8;
  localparam int unsigned OFF_W  = $clog2(BYTES);
  localparam int unsigned WORD_W = $clog2(LINE_WORDS);
  localparam int unsigned IDX_W  = $clog2(DEPTH);
  localparam int unsigned TAG_W  = ADDR_WIDTH - OFF_W - WORD_W - IDX_W;
  localparam int unsigned CNT_W  = (WORD_W == 0) ? 1 : WORD_W;
  localparam int unsigned IDX_SH = OFF_W + WORD_W;
  localparam int unsigned TAG_SH = IDX_SH + IDX_W;

`ifdef CACHE_FLUSH_EN
  typedef enum logic [2:0] {S_IDLE, S_WBACK, S_FILL, S_FLUSH, S_FLUSH_WB} state_e;
`else
  typedef enum logic [1:0] {S_IDLE, S_WBACK, S_FILL} state_e;
`endif

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        beat_q, beat_d;
  logic [IDX_W-1:0]        req_idx_q, req_idx_d;
  logic [TAG_W-1:0]        req_tag_q, req_tag_d;
  logic [DEPTH-1:0]        valid_q, dirty_q;
  logic [TAG_W-1:0]        tag_q  [DEPTH];
  logic [DATA_WIDTH-1:0]   data_q [DEPTH][LINE_WORDS];

  logic [IDX_W-1:0]        a_idx;
  logic [TAG_W-1:0]        a_tag;
  logic [CNT_W-1:0]        a_word;
  logic                    req_c, hit_c, beat_last_c;
  logic                    hit_wr_c, fill_we_c, fill_done_c;

`ifdef CACHE_FLUSH_EN
  logic [IDX_W-1:0]        flush_idx_q, flush_idx_d;
  logic                    flush_done_q, flush_done_d;
  logic                    wb_clean_c;
  assign flush_done_o = flush_done_q;
`endif

  // Burst beat address {tag, idx, word, byte 0}
  function automatic logic [ADDR_WIDTH-1:0] beat_addr(input logic [TAG_W-1:0] tag,
                                                      input logic [IDX_W-1:0] idx,
                                                      input logic [CNT_W-1:0] k);
    return (ADDR_WIDTH'(tag) << TAG_SH) | (ADDR_WIDTH'(idx) << IDX_SH) | (ADDR_WIDTH'(k) << OFF_W);
  endfunction

  assign a_idx       = IDX_W'(core_addr_i >> IDX_SH);
  assign a_tag       = TAG_W'(core_addr_i >> TAG_SH);
  assign a_word      = CNT_W'((core_addr_i >> OFF_W) & ADDR_WIDTH'(LINE_WORDS - 1));
  assign req_c       = core_read_i | core_write_i;
  assign hit_c       = valid_q[a_idx] && (tag_q[a_idx] == a_tag);
  assign beat_last_c = (beat_q == CNT_W'(LINE_WORDS - 1));

  always_comb begin
    state_d      = state_q;
    beat_d       = beat_q;
    req_idx_d    = req_idx_q;
    req_tag_d    = req_tag_q;
    hit_wr_c     = 1'b0;
    fill_we_c    = 1'b0;
    fill_done_c  = 1'b0;
    core_ready_o = 1'b0;
    core_rdata_o = '0;
    dmem_read_o  = 1'b0;
    dmem_write_o = 1'b0;
    dmem_addr_o  = '0;
    dmem_wdata_o = '0;
    dmem_wstrb_o = '0;
`ifdef CACHE_FLUSH_EN
    flush_idx_d  = flush_idx_q;
    flush_done_d = 1'b0;
    wb_clean_c   = 1'b0;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (req_c) begin
          if (hit_c) begin
            core_ready_o = 1'b1;
            if (core_write_i) hit_wr_c = 1'b1;
            else              core_rdata_o = data_q[a_idx][a_word];
          end else begin
            req_idx_d = a_idx;
            req_tag_d = a_tag;
            beat_d    = '0;
            state_d   = (valid_q[a_idx] && dirty_q[a_idx]) ? S_WBACK : S_FILL;
          end
        end
`ifdef CACHE_FLUSH_EN
        else if (flush_i) begin
          flush_idx_d = '0;
          beat_d      = '0;
          state_d     = S_FLUSH;
        end
`endif
      end
      S_WBACK: begin
        dmem_write_o = 1'b1;
        dmem_wstrb_o = '1;
        dmem_addr_o  = beat_addr(tag_q[req_idx_q], req_idx_q, beat_q);
        dmem_wdata_o = data_q[req_idx_q][beat_q];
        if (dmem_ready_i) begin
          beat_d = beat_q + CNT_W'(1);
          if (beat_last_c) begin
            beat_d  = '0;
            state_d = S_FILL;
          end
        end
      end
      S_FILL: begin
        dmem_read_o = 1'b1;
        dmem_addr_o = beat_addr(req_tag_q, req_idx_q, beat_q);
        if (dmem_ready_i) begin
          fill_we_c = 1'b1;
          beat_d    = beat_q + CNT_W'(1);
          if (beat_last_c) begin
            beat_d      = '0;
            fill_done_c = 1'b1;
            state_d     = S_IDLE;
          end
        end
      end
`ifdef CACHE_FLUSH_EN
      // Clean lines are skipped in one cycle; dirty ones drop into a writeback burst
      S_FLUSH: begin
        if (valid_q[flush_idx_q] && dirty_q[flush_idx_q]) begin
          beat_d  = '0;
          state_d = S_FLUSH_WB;
        end else if (flush_idx_q == IDX_W'(DEPTH - 1)) begin
          flush_done_d = 1'b1;
          state_d      = S_IDLE;
        end else begin
          flush_idx_d = flush_idx_q + IDX_W'(1);
        end
      end
      S_FLUSH_WB: begin
        dmem_write_o = 1'b1;
        dmem_wstrb_o = '1;
        dmem_addr_o  = beat_addr(tag_q[flush_idx_q], flush_idx_q, beat_q);
        dmem_wdata_o = data_q[flush_idx_q][beat_q];
        if (dmem_ready_i) begin
          beat_d = beat_q + CNT_W'(1);
          if (beat_last_c) begin
            beat_d     = '0;
            wb_clean_c = 1'b1;
            if (flush_idx_q == IDX_W'(DEPTH - 1)) begin
              flush_done_d = 1'b1;
              state_d      = S_IDLE;
            end else begin
              flush_idx_d = flush_idx_q + IDX_W'(1);
              state_d     = S_FLUSH;
            end
          end
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  // Control state and per-line valid/dirty; reset aborts any burst
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      beat_q       <= '0;
      req_idx_q    <= '0;
      req_tag_q    <= '0;
      valid_q      <= '0;
      dirty_q      <= '0;
`ifdef CACHE_FLUSH_EN
      flush_idx_q  <= '0;
      flush_done_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      beat_q    <= beat_d;
      req_idx_q <= req_idx_d;
      req_tag_q <= req_tag_d;
      if (fill_done_c) begin
        valid_q[req_idx_q] <= 1'b1;
        dirty_q[req_idx_q] <= 1'b0;
      end
      if (hit_wr_c) dirty_q[a_idx] <= 1'b1;
`ifdef CACHE_FLUSH_EN
      flush_idx_q  <= flush_idx_d;
      flush_done_q <= flush_done_d;
      if (wb_clean_c) dirty_q[flush_idx_q] <= 1'b0;
`endif
    end
  end

  // Tag and data storage, not reset
  always_ff @(posedge clk) begin
    if (fill_we_c) data_q[req_idx_q][beat_q] <= dmem_rdata_i;
    if (fill_done_c) tag_q[req_idx_q] <= req_tag_q;
    if (hit_wr_c) begin
      for (int unsigned b = 0; b < BYTES; b++) begin
        if (core_wstrb_i[b]) data_q[a_idx][a_word][8*b +: 8] <= core_wdata_i[8*b +: 8];
      end
    end
  end

endmodule
